// File: rtl/latch_strobe_gen.sv
// Time-multiplexed write engine for a bank of D latches: shared data line plus
// one-hot enables, sequenced SETUP/OPEN/HOLD. Optional readback: LATCH_READBACK_EN.
module latch_strobe_gen #(
    parameter int N_LATCH   = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    localparam int AW       = $clog2(N_LATCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_addr,
    input  logic              in_bit,
    output logic              d,
    output logic [N_LATCH-1:0] en,
`ifdef LATCH_READBACK_EN
    input  logic [N_LATCH-1:0] q,
    output logic              chk_err,
`endif
    output logic              busy,
    output logic              addr_err
);

    localparam int MAX_SO = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int MAX_C  = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
    localparam int CW     = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        addr_q;
    logic                 data_q;
    logic                 range_q;
    logic [N_LATCH-1:0]   en_q, en_d;
    logic                 addr_err_q;
    logic                 accept;
    logic                 addr_ok;
    logic                 ready_c;

    // A power-of-two bank has no unreachable addresses, so skip the compare.
    generate
        if ((1 << AW) == N_LATCH) begin : g_full_range
            assign addr_ok = 1'b1;
        end else begin : g_part_range
            assign addr_ok = ({1'b0, in_addr} < (AW+1)'(N_LATCH));
        end
    endgenerate

    assign accept = in_valid & ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter is reloaded with (phase length - 1) on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = OPEN;
                    cnt_d   = CW'(OPEN_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            OPEN: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready_c = (state_q == IDLE);
    end

    // Enables are decoded from the next state so the registered en lines up
    // exactly with the OPEN cycles.
    generate
        for (genvar gi = 0; gi < N_LATCH; gi++) begin : g_en
            assign en_d[gi] = (state_d == OPEN) & range_q & (addr_q == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            data_q     <= 1'b0;
            range_q    <= 1'b0;
            en_q       <= '0;
            addr_err_q <= 1'b0;
        end else begin
            en_q       <= en_d;
            addr_err_q <= accept & ~addr_ok;
            if (accept) begin
                addr_q  <= in_addr;
                data_q  <= in_bit;
                range_q <= addr_ok;
            end
        end
    end

`ifdef LATCH_READBACK_EN
    logic chk_err_q;
    logic last_hold;

    assign last_hold = (state_q == HOLD) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else if (last_hold && range_q && (q[addr_q] != data_q)) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`endif

    assign in_ready = ready_c;
    assign busy     = ~ready_c;
    assign d        = data_q;
    assign en       = en_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_latch_strobe_gen.sv
// Checks two latch_strobe_gen instances (default timing, and N=6 with 2/3/2
// timing) every cycle against a phase-arithmetic reference model.
module tb_latch_strobe_gen;

    localparam int N0 = 8, S0 = 1, O0 = 2, H0 = 1;
    localparam int N1 = 6, S1 = 2, O1 = 3, H1 = 2;
    localparam int NL [2] = '{N0, N1};
    localparam int SS [2] = '{S0, S1};
    localparam int OO [2] = '{O0, O1};
    localparam int HH [2] = '{H0, H1};
    localparam bit QT [2] = '{1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, b0 = 1'b0, v1 = 1'b0, b1 = 1'b0;
    logic [2:0] a0 = '0, a1 = '0;
    logic       r0, d0, busy0, err0, r1, d1, busy1, err1;
    logic [7:0] en0;
    logic [5:0] en1;
`ifdef LATCH_READBACK_EN
    logic [7:0] q0 = '0;
    logic [5:0] q1 = '1;
    logic       chk0, chk1;
`endif

    always #5 clk = ~clk;

    latch_strobe_gen #(.N_LATCH(N0), .SETUP_CYC(S0), .OPEN_CYC(O0), .HOLD_CYC(H0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .in_addr(a0),
        .in_bit(b0), .d(d0), .en(en0),
`ifdef LATCH_READBACK_EN
        .q(q0), .chk_err(chk0),
`endif
        .busy(busy0), .addr_err(err0));

    latch_strobe_gen #(.N_LATCH(N1), .SETUP_CYC(S1), .OPEN_CYC(O1), .HOLD_CYC(H1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_addr(a1),
        .in_bit(b1), .d(d1), .en(en1),
`ifdef LATCH_READBACK_EN
        .q(q1), .chk_err(chk1),
`endif
        .busy(busy1), .addr_err(err1));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int k_acc [2];
    int m_addr [2];
    bit m_bit [2];
    bit has [2];
    bit sticky [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit m_ready(input int i);
        return !has[i] || ((cyc - k_acc[i]) > SS[i] + OO[i] + HH[i]);
    endfunction

    function automatic bit m_inrange(input int i);
        return m_addr[i] < NL[i];
    endfunction

    task automatic check_cycle();
        for (int i = 0; i < 2; i++) begin
            int p;
            logic [63:0] e_en;
            bit e_err, e_chk, done_bad;
            p = cyc - k_acc[i];
            e_en = '0;
            if (has[i] && p > SS[i] && p <= SS[i] + OO[i] && m_inrange(i))
                e_en = 64'd1 << m_addr[i];
            e_err = has[i] && (p == 1) && !m_inrange(i);
            done_bad = has[i] && (p > SS[i] + OO[i] + HH[i]) && m_inrange(i) && (m_bit[i] != QT[i]);
            e_chk = sticky[i] | done_bad;
            sticky[i] = e_chk;
            if (i == 0) begin
                chk("ready0", 64'(r0), 64'(m_ready(0)));
                chk("busy0", 64'(busy0), 64'(!m_ready(0)));
                chk("d0", 64'(d0), 64'(has[0] ? m_bit[0] : 1'b0));
                chk("en0", 64'(en0), e_en);
                chk("addr_err0", 64'(err0), 64'(e_err));
                chk("onehot0", 64'($countones(en0) <= 1), 64'd1);
`ifdef LATCH_READBACK_EN
                chk("chk_err0", 64'(chk0), 64'(e_chk));
`endif
            end else begin
                chk("ready1", 64'(r1), 64'(m_ready(1)));
                chk("busy1", 64'(busy1), 64'(!m_ready(1)));
                chk("d1", 64'(d1), 64'(has[1] ? m_bit[1] : 1'b0));
                chk("en1", 64'(en1), e_en);
                chk("addr_err1", 64'(err1), 64'(e_err));
                chk("onehot1", 64'($countones(en1) <= 1), 64'd1);
`ifdef LATCH_READBACK_EN
                chk("chk_err1", 64'(chk1), 64'(e_chk));
`endif
            end
        end
    endtask

    // Check the current cycle, apply the model's accept rule, then advance one edge.
    task automatic tick();
        bit vv [2];
        int aa [2];
        bit bb [2];
        check_cycle();
        vv = '{v0, v1};
        aa = '{int'(a0), int'(a1)};
        bb = '{b0, b1};
        for (int i = 0; i < 2; i++) begin
            if (rst_n && vv[i] && m_ready(i)) begin
                has[i]    = 1'b1;
                k_acc[i]  = cyc;
                m_addr[i] = aa[i];
                m_bit[i]  = bb[i];
                $display("[TB] dut%0d accept cyc=%0d addr=%0d bit=%0d", i, cyc, aa[i], bb[i]);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            has[i]    = 1'b0;
            sticky[i] = 1'b0;
            k_acc[i]  = 0;
            m_addr[i] = 0;
            m_bit[i]  = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;

        // single write to latch 3
        v0 = 1'b1; a0 = 3'd3; b0 = 1'b1;
        tick();
        v0 = 1'b0;
        repeat (6) tick();

        // back-to-back writes with in_valid held
        v0 = 1'b1; a0 = 3'd0; b0 = 1'b1;
        tick();
        a0 = 3'd7; b0 = 1'b0;
        repeat (4) tick();
        v0 = 1'b0;
        repeat (6) tick();

        // out-of-range address on the 6-latch instance, plus an in-range one
        v1 = 1'b1; a1 = 3'd7; b1 = 1'b1;
        tick();
        v1 = 1'b0;
        repeat (9) tick();
        v1 = 1'b1; a1 = 3'd4; b1 = 1'b1;
        tick();
        v1 = 1'b0;
        repeat (9) tick();

        // reset asserted while dut0 is in OPEN
        v0 = 1'b1; a0 = 3'd5; b0 = 1'b1;
        tick();
        v0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_en0", 64'(en0), 64'd0);
        chk("rst_d0", 64'(d0), 64'd0);
        chk("rst_ready0", 64'(r0), 64'd1);
        chk("rst_busy0", 64'(busy0), 64'd0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        v0 = 1'b1; a0 = 3'd6; b0 = 1'b0;
        tick();
        v0 = 1'b0;
        repeat (6) tick();

        // randomized traffic on both instances
        for (int n = 0; n < 800; n++) begin
            v0 = ($urandom_range(0, 3) != 0);
            a0 = 3'($urandom_range(0, 7));
            b0 = 1'($urandom);
            v1 = ($urandom_range(0, 2) != 0);
            a1 = 3'($urandom_range(0, 7));
            b1 = 1'($urandom);
            tick();
        end
        v0 = 1'b0;
        v1 = 1'b0;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
